// File: rtl/pcs_checker_pkg.sv
// Shared widths, sync headers, block-type nibble table and lock states for the PCS checker.
package pcs_pkg;
  localparam int DATA_WIDTH           = 64;
  localparam int HDR_WIDTH            = 2;
  localparam int FRAME_WIDTH          = DATA_WIDTH + HDR_WIDTH;
  localparam int TRANSCODER_BLOCKS    = 4;
  localparam int TRANSCODER_WIDTH     = 257;
  localparam int TRANSCODER_HDR_WIDTH = 4;
  localparam int LOCK_COUNT           = 64;
  localparam int UNLOCK_COUNT         = 16;
  localparam int CNT_WIDTH            = 32;
  localparam int SCR_WIDTH            = 58;

  localparam logic [SCR_WIDTH-1:0] SCR_SEED  = 58'h3FF_FFFF_FFFF_FFFF;
  localparam logic [1:0]           SYNC_DATA = 2'b01;
  localparam logic [1:0]           SYNC_CTRL = 2'b10;

  // Index is the transmitted high nibble; entry 0 marks an illegal nibble.
  localparam logic [15:0][7:0] BLOCK_TYPE_TABLE = {
    8'hFF, 8'hE1, 8'hD2, 8'hCC, 8'hB4, 8'hAA, 8'h99, 8'h87,
    8'h78, 8'h66, 8'h55, 8'h4B, 8'h33, 8'h2D, 8'h1E, 8'h00
  };

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  function automatic logic [7:0] type_from_nibble(input logic [3:0] nib);
    return BLOCK_TYPE_TABLE[nib];
  endfunction

  function automatic logic type_is_valid(input logic [7:0] type_byte);
    logic ok;
    ok = 1'b0;
    for (int n = 1; n < 16; n++) begin
      if (BLOCK_TYPE_TABLE[n] == type_byte) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic [2:0] inc);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, cnt} + {{(CNT_WIDTH-2){1'b0}}, inc};
    return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/pcs_checker_if.sv
// Word input / decoded-block output bundle of the PCS checker.
interface pcs_checker_if;
  import pcs_pkg::*;

  logic                        i_valid;
  logic [TRANSCODER_WIDTH-1:0] i_scrambler;
  logic                        o_valid;
  logic [FRAME_WIDTH-1:0]      o_frame_0;
  logic [FRAME_WIDTH-1:0]      o_frame_1;
  logic [FRAME_WIDTH-1:0]      o_frame_2;
  logic [FRAME_WIDTH-1:0]      o_frame_3;
  logic                        o_lock;
  logic                        o_word_err;
  logic [CNT_WIDTH-1:0]        o_err_cnt;
  logic [CNT_WIDTH-1:0]        o_data_blk_cnt;
  logic [CNT_WIDTH-1:0]        o_ctrl_blk_cnt;

  modport master (
    output i_valid, i_scrambler,
    input  o_valid, o_frame_0, o_frame_1, o_frame_2, o_frame_3,
    input  o_lock, o_word_err, o_err_cnt, o_data_blk_cnt, o_ctrl_blk_cnt
  );

  modport slave (
    input  i_valid, i_scrambler,
    output o_valid, o_frame_0, o_frame_1, o_frame_2, o_frame_3,
    output o_lock, o_word_err, o_err_cnt, o_data_blk_cnt, o_ctrl_blk_cnt
  );
endinterface

// File: rtl/pcs_checker_descrambler.sv
// 256-bit parallel self-synchronising x^58+x^39+1 descrambler; state moves only on valid words.
module pcs_descrambler
  import pcs_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid,
  input  logic [TRANSCODER_WIDTH-2:0] din,
  output logic [TRANSCODER_WIDTH-2:0] dout
);
  logic [SCR_WIDTH-1:0] state_reg;
  logic [SCR_WIDTH-1:0] state_next;

  // Bit 0 of din is the earliest received bit; the received (scrambled) bit feeds the state.
  always_comb begin
    state_next = state_reg;
    dout       = '0;
    for (int i = 0; i < TRANSCODER_WIDTH - 1; i++) begin
      dout[i]    = din[i] ^ state_next[38] ^ state_next[57];
      state_next = {state_next[SCR_WIDTH-2:0], din[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SCR_SEED;
    end else if (valid) begin
      state_reg <= state_next;
    end
  end
endmodule

// File: rtl/pcs_checker.sv
// PCS receive checker: descramble, 257b->4x66b reverse transcode, validate, block lock, error count.
// Optional PCS_CHECKER_STATS_EN adds saturating data/ctrl block counters (tied to 0 otherwise).
module pcs_checker
  import pcs_pkg::*;
(
  input  logic          clk,
  input  logic          i_rst_n,
  pcs_checker_if.slave  bus
);
  localparam int EXT_WIDTH = TRANSCODER_WIDTH + DATA_WIDTH - 1;
  localparam int GOOD_W    = $clog2(LOCK_COUNT);
  localparam int BAD_W     = $clog2(UNLOCK_COUNT);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_COUNT - 1);

  logic [TRANSCODER_WIDTH-2:0] descr_data;
  logic [TRANSCODER_WIDTH-1:0] word_reg;
  logic                        valid1_reg;

  pcs_descrambler u_descrambler (
    .clk   (clk),
    .rst_n (i_rst_n),
    .valid (bus.i_valid),
    .din   (bus.i_scrambler[TRANSCODER_WIDTH-1:1]),
    .dout  (descr_data)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_reg   <= '0;
      valid1_reg <= 1'b0;
    end else begin
      valid1_reg <= bus.i_valid;
      if (bus.i_valid) word_reg <= {descr_data, bus.i_scrambler[0]};
    end
  end

  logic [TRANSCODER_BLOCKS-1:0][FRAME_WIDTH-1:0] frame_next;
  logic                                          word_bad_next;
  logic [EXT_WIDTH-1:0]                          word_ext;

  // Zero extension keeps the walk in range when an illegal all-flags word overruns 257 bits.
  assign word_ext = {{(DATA_WIDTH-1){1'b0}}, word_reg};

  always_comb begin
    int         pos;
    logic       first_ctrl;
    logic [3:0] nib;
    logic [7:0] type_byte;
    logic [TRANSCODER_HDR_WIDTH-1:0] flags;
    frame_next    = '0;
    word_bad_next = 1'b0;
    pos           = TRANSCODER_HDR_WIDTH + 1;
    first_ctrl    = 1'b1;
    nib           = '0;
    type_byte     = '0;
    flags         = word_reg[TRANSCODER_HDR_WIDTH:1];
    for (int n = 0; n < TRANSCODER_BLOCKS; n++) begin
      if (word_reg[0]) begin
        frame_next[n] = {word_reg[DATA_WIDTH*n+1 +: DATA_WIDTH], SYNC_DATA};
      end else if (flags[n]) begin
        frame_next[n] = {word_ext[pos +: DATA_WIDTH], SYNC_DATA};
        pos           = pos + DATA_WIDTH;
      end else if (first_ctrl) begin
        // Only the type high nibble was sent; the table restores the full byte.
        nib           = word_ext[pos +: 4];
        frame_next[n] = {word_ext[pos+4 +: DATA_WIDTH-8], type_from_nibble(nib), SYNC_CTRL};
        if (nib == 4'h0) word_bad_next = 1'b1;
        pos           = pos + DATA_WIDTH - 4;
        first_ctrl    = 1'b0;
      end else begin
        type_byte     = word_ext[pos +: 8];
        frame_next[n] = {word_ext[pos +: DATA_WIDTH], SYNC_CTRL};
        if (!type_is_valid(type_byte)) word_bad_next = 1'b1;
        pos           = pos + DATA_WIDTH;
      end
    end
    if (!word_reg[0] && (&flags)) word_bad_next = 1'b1;
  end

  logic                                          valid2_reg;
  logic                                          word_err_reg;
  logic                                          lock_reg;
  logic [TRANSCODER_BLOCKS-1:0][FRAME_WIDTH-1:0] frame_reg;
  logic [CNT_WIDTH-1:0]                          err_cnt_reg;
  logic [GOOD_W-1:0]                             good_cnt_reg;
  logic [BAD_W-1:0]                              bad_cnt_reg;
  lock_state_t                                   state_reg;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid2_reg   <= 1'b0;
      word_err_reg <= 1'b0;
      lock_reg     <= 1'b0;
      frame_reg    <= '0;
      err_cnt_reg  <= '0;
      good_cnt_reg <= '0;
      bad_cnt_reg  <= '0;
      state_reg    <= UNLOCKED;
    end else begin
      valid2_reg   <= valid1_reg;
      word_err_reg <= valid1_reg & word_bad_next;
      if (valid1_reg) begin
        frame_reg <= frame_next;
        if (word_bad_next) err_cnt_reg <= sat_add(err_cnt_reg, 3'd1);
        case (state_reg)
          UNLOCKED: begin
            if (word_bad_next) begin
              good_cnt_reg <= '0;
            end else if (good_cnt_reg == GOOD_LAST) begin
              state_reg    <= LOCKED;
              lock_reg     <= 1'b1;
              good_cnt_reg <= '0;
              bad_cnt_reg  <= '0;
            end else begin
              good_cnt_reg <= good_cnt_reg + 1'b1;
            end
          end
          LOCKED: begin
            if (!word_bad_next) begin
              bad_cnt_reg <= '0;
            end else if (bad_cnt_reg == BAD_LAST) begin
              state_reg    <= UNLOCKED;
              lock_reg     <= 1'b0;
              good_cnt_reg <= '0;
              bad_cnt_reg  <= '0;
            end else begin
              bad_cnt_reg <= bad_cnt_reg + 1'b1;
            end
          end
          default: state_reg <= UNLOCKED;
        endcase
      end
    end
  end

  assign bus.o_valid    = valid2_reg;
  assign bus.o_word_err = word_err_reg;
  assign bus.o_lock     = lock_reg;
  assign bus.o_err_cnt  = err_cnt_reg;
  assign bus.o_frame_0  = frame_reg[0];
  assign bus.o_frame_1  = frame_reg[1];
  assign bus.o_frame_2  = frame_reg[2];
  assign bus.o_frame_3  = frame_reg[3];

`ifdef PCS_CHECKER_STATS_EN
  logic [TRANSCODER_BLOCKS-1:0] is_data;
  logic [2:0]                   data_add;
  logic [CNT_WIDTH-1:0]         data_cnt_reg;
  logic [CNT_WIDTH-1:0]         ctrl_cnt_reg;

  for (genvar gi = 0; gi < TRANSCODER_BLOCKS; gi++) begin : g_blk_kind
    assign is_data[gi] = (frame_next[gi][1:0] == SYNC_DATA);
  end

  assign data_add = 3'($countones(is_data));

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_cnt_reg <= '0;
      ctrl_cnt_reg <= '0;
    end else if (valid1_reg) begin
      data_cnt_reg <= sat_add(data_cnt_reg, data_add);
      ctrl_cnt_reg <= sat_add(ctrl_cnt_reg, 3'd4 - data_add);
    end
  end

  assign bus.o_data_blk_cnt = data_cnt_reg;
  assign bus.o_ctrl_blk_cnt = ctrl_cnt_reg;
`else
  assign bus.o_data_blk_cnt = '0;
  assign bus.o_ctrl_blk_cnt = '0;
`endif
endmodule
